rfs_wifi_pio_poller: RTL and testbench

Avalon-MM read initiator for the 8-bit switch input PIO slave on the RFS WiFi system bus. Issues a read of register 0 every POLL_DIV cycles, captures the low 8 bits of readdata, compares against the last sample and queues a change event (new value plus changed-bit mask) into a small show-ahead FIFO with a valid/ready output. Sits between the PIO slave and the WiFi reporting logic so the reporter sees switch edges, not raw levels.

---
 rtl/rfs_wifi_pio_pkg.sv | 10 +
 rtl/rfs_wifi_pio_evt_fifo.sv | 36 +++
 rtl/rfs_wifi_pio_poller.sv | 84 ++++++++
 tb/tb_rfs_wifi_pio_poller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rfs_wifi_pio_pkg.sv
// rfs_wifi_pio_pkg: shared widths, poll FSM states and change-event record for the switch PIO poller
package rfs_wifi_pio_pkg;
  localparam int PIO_W = 8;
  localparam int AVM_ADDR_W = 2;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;
  typedef struct packed {
    logic [PIO_W-1:0] data;
    logic [PIO_W-1:0] mask;
  } evt_t;
endpackage

// File: rtl/rfs_wifi_pio_evt_fifo.sv
// rfs_wifi_pio_evt_fifo: show-ahead change-event FIFO, full/empty from 1-bit-wider pointers
module rfs_wifi_pio_evt_fifo
  import rfs_wifi_pio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  evt_t din,
  output evt_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  evt_t mem [DEPTH];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  // a pop frees the head slot in the same edge, so a full FIFO still accepts
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/rfs_wifi_pio_poller.sv
// rfs_wifi_pio_poller: periodic Avalon-MM read of the switch PIO, queues value-change events
module rfs_wifi_pio_poller
  import rfs_wifi_pio_pkg::*;
#(
  parameter int POLL_DIV = 1000,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic [AVM_ADDR_W-1:0] avm_address,
  output logic                  avm_read,
  input  logic [31:0]           avm_readdata,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [PIO_W-1:0]      evt_data,
  output logic [PIO_W-1:0]      evt_mask,
  output logic [PIO_W-1:0]      cur_value,
  output logic                  overflow,
  input  logic                  ovf_clr
);
  localparam int DW = $clog2(POLL_DIV);
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam logic [DW-1:0] DIV_INIT = DW'(POLL_DIV - 1);
  // ISSUE, WAIT and CAPTURE consume READ_LATENCY+2 cycles of the period
  localparam logic [DW-1:0] DIV_RELOAD = DW'(POLL_DIV - READ_LATENCY - 3);
  state_t state;
  logic [DW-1:0] div;
  logic [LW-1:0] lat;
  logic [PIO_W-1:0] sample;
  logic first_done, push, full, empty, drop, unused_hi;
  evt_t head;
  assign avm_address = '0;
  assign avm_read = state == S_ISSUE;
  assign sample = avm_readdata[PIO_W-1:0];
  assign unused_hi = ^avm_readdata[31:PIO_W];
  assign push = (state == S_CAPTURE) && (!first_done || sample != cur_value);
  assign drop = push && full && !evt_ready;
  assign evt_valid = !empty;
  assign evt_data = head.data;
  assign evt_mask = head.mask;
  rfs_wifi_pio_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (evt_ready),
    .din    ({sample, sample ^ cur_value}),
    .dout   (head),
    .full   (full),
    .empty  (empty)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      div <= DIV_INIT;
      lat <= '0;
      cur_value <= '0;
      first_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop || (overflow && !ovf_clr);
      case (state)
        S_IDLE: begin
          div <= enable ? div - 1'b1 : DIV_INIT;
          if (enable && div == '0) state <= S_ISSUE;
        end
        S_ISSUE: begin
          lat <= LW'(READ_LATENCY);
          state <= S_WAIT;
        end
        S_WAIT: begin
          lat <= lat - 1'b1;
          if (lat == LW'(1)) state <= S_CAPTURE;
        end
        default: begin
          cur_value <= sample;
          first_done <= 1'b1;
          div <= DIV_RELOAD;
          state <= S_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_rfs_wifi_pio_poller.sv
// tb_rfs_wifi_pio_poller: vector table, corner sequences and random traffic against a cycle-number model
module tb_rfs_wifi_pio_poller;
  localparam int P = 8;
  localparam int L = 1;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset_n, enable, evt_ready, ovf_clr;
  logic [7:0] sw;
  logic [23:0] hi;
  logic [31:0] avm_readdata;
  logic [1:0] avm_address;
  logic avm_read, evt_valid, overflow;
  logic [7:0] evt_data, evt_mask, cur_value;

  assign avm_readdata = {hi, sw};
  always #5 clk = ~clk;

  rfs_wifi_pio_poller #(.POLL_DIV(P), .READ_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .avm_address (avm_address),
    .avm_read    (avm_read),
    .avm_readdata(avm_readdata),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_data    (evt_data),
    .evt_mask    (evt_mask),
    .cur_value   (cur_value),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  int checks = 0;
  int failures = 0;

  // Reference: n is the cycle index (cycle k follows the k-th edge after reset release);
  // issue_c is the cycle of the latest read strobe, ready_at the earliest cycle the next may come.
  int n, issue_c, ready_at;
  bit first, ovf;
  logic [7:0] cur;
  logic [15:0] q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, n, got, exp);
    end
  endtask

  task automatic model_reset();
    n = -1;
    issue_c = -100;
    ready_at = P - 1;
    first = 0;
    ovf = 0;
    cur = 8'h00;
    q.delete();
  endtask

  task automatic model_edge();
    bit cap, idle, pop, push, drop;
    cap = (n == issue_c + L + 1);
    idle = (n < issue_c) || (n > issue_c + L + 1);
    pop = (q.size() > 0) && evt_ready;
    push = cap && (!first || sw != cur);
    drop = 0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < D) q.push_back({sw, sw ^ cur});
      else drop = 1;
    end
    ovf = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf);
    if (cap) begin
      cur = sw;
      first = 1;
      ready_at = issue_c + P;
    end
    if (idle) begin
      if (!enable) ready_at = n + P + 1;
      else if (n + 1 >= ready_at) issue_c = n + 1;
    end
  endtask

  task automatic chk_model();
    logic v;
    logic [15:0] h;
    v = q.size() > 0;
    h = v ? q[0] : 16'h0;
    chk("model", {avm_address, avm_read, evt_valid, evt_valid ? {evt_data, evt_mask} : 16'h0, cur_value, overflow},
        {2'b00, n == issue_c, v, h, cur, ovf});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    n++;
    hi = 24'($urandom);
    chk_model();
  endtask

  task automatic do_reset(input int hold);
    reset_n = 1'b0;
    #1;
    chk("reset_outputs", {avm_address, avm_read, evt_valid, evt_data, evt_mask, cur_value, overflow}, 64'h0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    chk_model();
  endtask

  task automatic to_phase(input int off, input string name);
    int g = 0;
    do begin
      step();
      g++;
    end while (n != issue_c + off && g < 4 * P);
    if (n != issue_c + off) begin
      checks++;
      failures++;
      $display("FAIL %s: phase not reached within %0d cycles", name, g);
    end
  endtask

  task automatic drain(input string name, input logic [15:0] exp[4]);
    for (int i = 0; i < 4; i++) begin
      chk(name, {evt_valid, evt_data, evt_mask}, {1'b1, exp[i]});
      evt_ready = 1'b1;
      step();
    end
    evt_ready = 1'b0;
    chk({name, "_empty"}, evt_valid, 1'b0);
  endtask

  typedef struct {
    logic [7:0] sw;
    logic v;
    logic [7:0] d;
    logic [7:0] m;
    logic [7:0] cur;
  } row_t;
  row_t rows[7];
  logic [7:0] pal[4];
  logic [15:0] exp4[4];

  initial begin
    rows[0] = '{8'hA5, 1'b1, 8'hA5, 8'hA5, 8'hA5};
    rows[1] = '{8'hA5, 1'b0, 8'h00, 8'h00, 8'hA5};
    rows[2] = '{8'hA4, 1'b1, 8'hA4, 8'h01, 8'hA4};
    rows[3] = '{8'hFF, 1'b1, 8'hFF, 8'h5B, 8'hFF};
    rows[4] = '{8'hFF, 1'b0, 8'h00, 8'h00, 8'hFF};
    rows[5] = '{8'h00, 1'b1, 8'h00, 8'hFF, 8'h00};
    rows[6] = '{8'h81, 1'b1, 8'h81, 8'h81, 8'h81};
    pal = '{8'h3C, 8'h3D, 8'hC3, 8'h00};
    reset_n = 1'b1;
    enable = 1'b0;
    evt_ready = 1'b0;
    ovf_clr = 1'b0;
    sw = 8'hA5;
    hi = 24'h5A5A5A;
    model_reset();
    #2;
    do_reset(2);
    enable = 1'b1;

    // one poll per row, observed the cycle after CAPTURE, then the event is consumed
    for (int k = 0; k < 7; k++) begin
      sw = rows[k].sw;
      to_phase(L + 2, "row_poll");
      chk("row", {evt_valid, evt_valid ? {evt_data, evt_mask} : 16'h0, cur_value},
          {rows[k].v, rows[k].d, rows[k].m, rows[k].cur});
      if (rows[k].v) begin
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
      end
    end

    // five changes with no consumer: four held, fifth dropped
    for (int k = 1; k <= 5; k++) begin
      sw = 8'(k * 16);
      to_phase(L + 2, "ovf_poll");
    end
    chk("ovf_set", {overflow, cur_value}, {1'b1, 8'h50});
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 1'b0);
    exp4 = '{16'h1091, 16'h2030, 16'h3010, 16'h4070};
    drain("ovf_drain", exp4);

    // refill, then a change captured on the same edge as a pop
    for (int k = 0; k < 4; k++) begin
      sw = 8'(8'h60 + k);
      to_phase(L + 2, "fill_poll");
    end
    sw = 8'h64;
    to_phase(L + 1, "full_capture");
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("full_pop_ovf", overflow, 1'b0);
    exp4 = '{16'h6101, 16'h6203, 16'h6301, 16'h6407};
    drain("full_pop_order", exp4);

    // enable drops in WAIT: transaction completes, then silence, then re-enable timing
    sw = 8'h70;
    to_phase(1, "en_wait");
    enable = 1'b0;
    to_phase(L + 2, "en_capture");
    chk("en_drop_event", {evt_valid, evt_data, evt_mask}, {1'b1, 8'h70, 8'h14});
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    begin
      int reads = 0;
      for (int i = 0; i < 3 * P; i++) begin
        step();
        reads += int'(avm_read);
      end
      chk("no_read_disabled", reads, 0);
    end
    enable = 1'b1;
    begin
      int t = 0;
      do begin
        step();
        t++;
      end while (!avm_read && t < 3 * P);
      chk("reenable_issue", t, P);
    end

    // reset inside WAIT; same switch value must still be reported afterwards
    to_phase(1, "rst_wait");
    do_reset(2);
    to_phase(L + 2, "rst_poll");
    chk("post_reset_event", {evt_valid, evt_data, evt_mask, cur_value}, {1'b1, 8'h70, 8'h70, 8'h70});

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset(1);
      enable = $urandom_range(0, 39) != 0;
      if ($urandom_range(0, 4) == 0) sw = pal[$urandom_range(0, 3)];
      evt_ready = $urandom_range(0, 3) == 0;
      ovf_clr = $urandom_range(0, 19) == 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
